// File: rtl/dmem.sv
`default_nettype none
// ============================================================================
//  Module   : dmem
//  Purpose  : Word-addressed data memory. Combinational read, synchronous
//             full-word write, asynchronous clear of every word on reset.
//             Byte addresses wrap modulo 4*DEPTH bytes.
//
//  Ports    : clk      - rising-edge clock for writes
//             reset    - asynchronous, active-high; clears every word, holds rd
//                        at 0 and blocks writes while high
//             we       - write enable, sampled at the rising edge of clk
//             a        - byte address; word index is a[log2(DEPTH)+1:2]
//             wd       - write data
//             rd       - read data, rd = mem[index] with no clock latency
//             misalign - a[1:0] != 0 when the alignment check is built in,
//                        otherwise tied to 0
//
//  Config   : DMEM_ALIGN_CHECK_EN - when defined, misaligned addresses raise
//             misalign and their writes are dropped; reads still return
//             mem[index]. When undefined, a[1:0] is ignored entirely.
//
//  Revision : 1.0 - initial release
// ============================================================================
module dmem #(
    parameter int DEPTH = 64,   // number of words, power of two, >= 2
    parameter int WIDTH = 32    // data width, only 32 is supported
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [31:0]      a,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             misalign
);

    localparam int c_IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_IDX_W-1:0] w_idx;
    logic               w_misalign;
    logic               w_wr;

    // Bits above the index select nothing; this is what makes addresses wrap.
    assign w_idx = a[c_IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = |a[1:0];
    // Upper address bits intentionally ignored.
    logic w_unused_a;
    assign w_unused_a = ^{1'b0, a[31:c_IDX_W+2]};
`else
    assign w_misalign = 1'b0;
    // Upper address bits and the byte offset are intentionally ignored.
    logic w_unused_a;
    assign w_unused_a = ^{1'b0, a[31:c_IDX_W+2], a[1:0]};
`endif

    assign misalign = w_misalign;

    // A misaligned write is dropped rather than rounded down to the word.
    assign w_wr = we & ~w_misalign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[w_idx] <= wd;
        end
    end

    // The index is always in range (DEPTH is a power of two), so rd is never X
    // once reset has cleared the array. The reset gate keeps rd at 0 even in
    // the instant between reset rising and the array clear propagating.
    assign rd = reset ? '0 : r_mem[w_idx];

endmodule
`default_nettype wire

// File: tb/tb_dmem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem
//  Purpose  : Self-checking bench for dmem: directed vector table, reset and
//             reset-dominance sequences, and random traffic compared against
//             a plain array model of the memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        misalign;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] model [DEPTH];

    dmem #(.DEPTH(DEPTH), .WIDTH(32)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge, let the rising edge happen, sample 1ns later.
    task automatic cycle(input logic w, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = w;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    function automatic bit addr_misaligned(input logic [31:0] addr);
`ifdef DMEM_ALIGN_CHECK_EN
        return (addr % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        logic [31:0] r_addr;
        logic        r_we;
        logic [31:0] r_wd;

        reset = 1'b0;
        we    = 1'b0;
        a     = '0;
        wd    = '0;

        // Reset pulsed mid-cycle; rd must be 0 while reset is high.
        #2 reset = 1'b1;
        #1 check("rd_during_reset", rd, 32'h0);
        #3 reset = 1'b0;

        // Put something in memory, then clear it with an asynchronous pulse.
        cycle(1'b1, 32'h20, 32'h0BADF00D);
        check("pre_reset_write", rd, 32'h0BADF00D);
        @(negedge clk);
        we = 1'b0;
        #2 reset = 1'b1;
        #1 check("rd_async_reset", rd, 32'h0);
        #1 reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            a = 32'(i * 4);
            #1 check("reset_sweep", rd, 32'h0);
        end

        // Directed vectors.
        vecs[0]  = '{1'b1, 32'h004, 32'h12345678, 32'h12345678, 1'b0};
        vecs[1]  = '{1'b0, 32'h004, 32'hFFFFFFFF, 32'h12345678, 1'b0};
        vecs[2]  = '{1'b1, 32'h008, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0};
        vecs[3]  = '{1'b0, 32'h008, 32'h00000000, 32'hAABBCCDD, 1'b0};
        vecs[4]  = '{1'b0, 32'h004, 32'h00000000, 32'h12345678, 1'b0};
        vecs[5]  = '{1'b0, 32'h00C, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b1, 32'h100, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[7]  = '{1'b0, 32'h000, 32'h00000000, 32'hCAFEF00D, 1'b0};
        vecs[8]  = '{1'b1, 32'h010, 32'h11111111, 32'h11111111, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        vecs[9]  = '{1'b1, 32'h011, 32'h22222222, 32'h11111111, 1'b1};
        vecs[10] = '{1'b0, 32'h010, 32'h00000000, 32'h11111111, 1'b0};
        vecs[11] = '{1'b0, 32'h013, 32'h00000000, 32'h11111111, 1'b1};
`else
        vecs[9]  = '{1'b1, 32'h011, 32'h22222222, 32'h22222222, 1'b0};
        vecs[10] = '{1'b0, 32'h010, 32'h00000000, 32'h22222222, 1'b0};
        vecs[11] = '{1'b0, 32'h013, 32'h00000000, 32'h22222222, 1'b0};
`endif
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].we, vecs[i].a, vecs[i].wd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
        end

        // Reset dominates a simultaneous write.
        @(negedge clk);
        we    = 1'b1;
        a     = 32'h14;
        wd    = 32'h55555555;
        reset = 1'b1;
        @(posedge clk);
        #1 check("reset_dom_during", rd, 32'h0);
        @(negedge clk);
        we    = 1'b0;
        reset = 1'b0;
        #1 check("reset_dom_after", rd, 32'h0);
        a = 32'h004;
        #1 check("reset_cleared_other", rd, 32'h0);

        // First write after deassertion lands on the next enabled edge.
        cycle(1'b1, 32'h14, 32'h5A5A5A5A);
        check("first_write_after_reset", rd, 32'h5A5A5A5A);

        // Random traffic against the array model (start from a fresh reset).
        @(negedge clk);
        we = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        for (int n = 0; n < 400; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_addr = $urandom;
            if (n % 3 == 0) r_addr = r_addr & 32'h0000_01FF;
            r_wd   = $urandom;
            @(negedge clk);
            we = r_we;
            a  = r_addr;
            wd = r_wd;
            #1;
            check("rand_read_before", rd, model[widx(r_addr)]);
            check("rand_misalign", {31'b0, misalign}, {31'b0, addr_misaligned(r_addr)});
            @(posedge clk);
            if (r_we && !addr_misaligned(r_addr)) model[widx(r_addr)] = r_wd;
            #1;
            check("rand_read_after", rd, model[widx(r_addr)]);
        end

        // Full comparison of the array after random traffic.
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            a = 32'(i * 4);
            #1 check("final_sweep", rd, model[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
